// File: rtl/cfg_rx_pkg.sv
// Shared constants for the configuration frame receiver: state encoding,
// default geometry and the 16-bit frame fold used by the optional checksum.
package cfg_rx_pkg;

  localparam int DEF_FRAME_W    = 224;
  localparam int DEF_NUM_FRAMES = 245;
  localparam int DEF_IDX_W      = 8;

  // Widest frame the fold helper accepts; callers zero-extend narrower frames.
  localparam int FOLD_MAX_W = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  function automatic logic [15:0] fold16(input logic [FOLD_MAX_W-1:0] data);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_W / 16; i++) begin
      acc = acc ^ data[i*16 +: 16];
    end
    return acc;
  endfunction

endpackage

// File: rtl/cfg_frame_store.sv
// Frame storage: one write port, one registered read port. Reads of indices
// beyond NUM_FRAMES return zero; a same-cycle read of a written index sees old data.
module cfg_frame_store #(
  parameter int FRAME_W    = 224,
  parameter int NUM_FRAMES = 245,
  parameter int IDX_W      = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [FRAME_W-1:0] rd_data,
  output logic               rd_valid
);

  localparam int AW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic [FRAME_W-1:0] r_mem [NUM_FRAMES];
  logic [AW-1:0]      w_wr_idx;
  logic [AW-1:0]      w_rd_idx;
  logic               w_rd_in_range;

  assign w_wr_idx      = wr_addr[AW-1:0];
  assign w_rd_idx      = rd_addr[AW-1:0];
  assign w_rd_in_range = ({1'b0, rd_addr} < (IDX_W+1)'(NUM_FRAMES));

  // Storage is deliberately not reset so frames survive a mid-load reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
      end
    end
  end

endmodule

// File: rtl/cfg_frame_receiver.sv
// Fabric-side endpoint of the configuration frame-load protocol.
// Optional checksum output enabled by defining CFG_RX_CHECKSUM_EN.
module cfg_frame_receiver
  import cfg_rx_pkg::*;
#(
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int IDX_W      = DEF_IDX_W
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [FRAME_W-1:0]    configs_in,
  input  logic [NUM_FRAMES-1:0] configs_en,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [IDX_W-1:0]      cfg_err_idx,
  output logic [IDX_W:0]        cfg_frame_cnt,
  input  logic                  rb_en,
  input  logic [IDX_W-1:0]      rb_addr,
  output logic [FRAME_W-1:0]    rb_data,
  output logic                  rb_valid
`ifdef CFG_RX_CHECKSUM_EN
  ,
  output logic [15:0]           cfg_checksum
`endif
);

  localparam logic [NUM_FRAMES-1:0] EN_ONE   = {{(NUM_FRAMES-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_FRAMES - 1);

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_cur_idx;
  logic [FRAME_W-1:0]    r_cur_frame;
  logic                  r_done;
  logic                  r_err;
  logic [IDX_W-1:0]      r_err_idx;
  logic [IDX_W:0]        r_frame_cnt;

  logic [NUM_FRAMES-1:0] w_bit_k;
  logic [NUM_FRAMES-1:0] w_bit_k1;
  logic                  w_is_last;
  logic                  w_hold;
  logic                  w_step;
  logic                  w_finish;
  logic                  w_commit;

  // The last-frame guard matters: shifting past the top bit yields all-zero.
  assign w_bit_k   = EN_ONE << r_cur_idx;
  assign w_bit_k1  = w_bit_k << 1;
  assign w_is_last = (r_cur_idx == LAST_IDX);
  assign w_hold    = (configs_en == w_bit_k);
  assign w_step    = !w_is_last && (configs_en == w_bit_k1);
  assign w_finish  = w_is_last && (configs_en == '0);
  assign w_commit  = (r_state == ST_LOAD) && (w_step || w_finish);

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur_idx   <= '0;
      r_cur_frame <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_idx   <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (configs_en == EN_ONE) begin
            r_state     <= ST_LOAD;
            r_cur_idx   <= '0;
            r_cur_frame <= configs_in;
          end else if (configs_en != '0) begin
            r_state   <= ST_ERROR;
            r_err     <= 1'b1;
            r_err_idx <= r_cur_idx;
          end
        end
        ST_LOAD: begin
          if (w_hold) begin
            r_cur_frame <= configs_in;
          end else if (w_step) begin
            r_cur_idx   <= r_cur_idx + IDX_W'(1);
            r_frame_cnt <= r_frame_cnt + (IDX_W+1)'(1);
            r_cur_frame <= configs_in;
          end else if (w_finish) begin
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + (IDX_W+1)'(1);
          end else begin
            r_state   <= ST_ERROR;
            r_err     <= 1'b1;
            r_err_idx <= r_cur_idx;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign cfg_done      = r_done;
  assign cfg_err       = r_err;
  assign cfg_err_idx   = r_err_idx;
  assign cfg_frame_cnt = r_frame_cnt;

  cfg_frame_store #(
    .FRAME_W    (FRAME_W),
    .NUM_FRAMES (NUM_FRAMES),
    .IDX_W      (IDX_W)
  ) u_store (
    .clock    (clock),
    .rst      (rst),
    .wr_en    (w_commit),
    .wr_addr  (r_cur_idx),
    .wr_data  (r_cur_frame),
    .rd_en    (rb_en),
    .rd_addr  (rb_addr),
    .rd_data  (rb_data),
    .rd_valid (rb_valid)
  );

`ifdef CFG_RX_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Only commits update the sum, so it freezes naturally in DONE and ERROR.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_commit) begin
      r_checksum <= {r_checksum[14:0], r_checksum[15]} ^ fold16(FOLD_MAX_W'(r_cur_frame));
    end
  end

  assign cfg_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_cfg_frame_receiver.sv
// Self-checking bench for cfg_frame_receiver with 16-bit frames, 4 frames.
// Checks the checksum output too when CFG_RX_CHECKSUM_EN is defined.
module tb_cfg_frame_receiver;

  localparam int FW = 16;
  localparam int NF = 4;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          rst;
  logic [FW-1:0] configs_in;
  logic [NF-1:0] configs_en;
  logic          cfg_done;
  logic          cfg_err;
  logic [IW-1:0] cfg_err_idx;
  logic [IW:0]   cfg_frame_cnt;
  logic          rb_en;
  logic [IW-1:0] rb_addr;
  logic [FW-1:0] rb_data;
  logic          rb_valid;
`ifdef CFG_RX_CHECKSUM_EN
  logic [15:0]   cfg_checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] exp_q[$];

  cfg_frame_receiver #(.FRAME_W(FW), .NUM_FRAMES(NF), .IDX_W(IW)) dut (
    .clock         (clock),
    .rst           (rst),
    .configs_in    (configs_in),
    .configs_en    (configs_en),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .cfg_err_idx   (cfg_err_idx),
    .cfg_frame_cnt (cfg_frame_cnt),
    .rb_en         (rb_en),
    .rb_addr       (rb_addr),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid)
`ifdef CFG_RX_CHECKSUM_EN
    ,
    .cfg_checksum  (cfg_checksum)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; configs_en = '0; configs_in = '0; rb_en = 1'b0; rb_addr = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [NF-1:0] en, input logic [FW-1:0] d);
    configs_en = en;
    configs_in = d;
    step();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic [IW-1:0] idx, input logic [IW:0] cnt);
    check({tag, ".done"}, 32'(cfg_done), 32'(d));
    check({tag, ".err"},  32'(cfg_err),  32'(e));
    check({tag, ".idx"},  32'(cfg_err_idx), 32'(idx));
    check({tag, ".cnt"},  32'(cfg_frame_cnt), 32'(cnt));
  endtask

  task automatic rb_read(input logic [IW-1:0] a, input logic [FW-1:0] e, input string nm);
    exp_q.push_back(e);
    rb_en = 1'b1; rb_addr = a;
    step();
    rb_en = 1'b0;
    check({nm, ".valid"}, 32'(rb_valid), 32'd1);
    check({nm, ".data"},  32'(rb_data),  32'(exp_q.pop_front()));
  endtask

  // Reference checksum: rotate-left-by-one then XOR, over the committed frames.
  function automatic logic [15:0] model_csum(input logic [FW-1:0] fr[$]);
    int c;
    c = 0;
    foreach (fr[i]) begin
      c = ((c * 2) % 65536) + (c / 32768);
      c = c ^ int'(fr[i]);
    end
    return c[15:0];
  endfunction

  // Legal load of all frames, each held two cycles, data base+index.
  task automatic full_load(input logic [FW-1:0] base);
    for (int f = 0; f < NF; f++) begin
      drive(NF'(1 << f), base + FW'(f));
      drive(NF'(1 << f), base + FW'(f));
    end
    drive('0, '0);
  endtask

  typedef struct {
    logic [NF-1:0] en;
    logic [FW-1:0] data;
    logic          rbe;
    logic [IW-1:0] rba;
    logic          done;
    logic          err;
    logic [IW:0]   cnt;
    logic          rbv;
    logic [FW-1:0] rbd;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [FW-1:0] frames[$];
    logic [FW-1:0] last_d;
    logic [NF-1:0] bad;
    int err_at, legal_next, hold;

    // ---- nominal load, table-driven ----
    tbl[0]  = '{4'd1, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0};
    tbl[1]  = '{4'd1, 16'hA001, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0};
    tbl[2]  = '{4'd1, 16'hA001, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0};
    tbl[3]  = '{4'd2, 16'hB002, 1'b0, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0, 16'h0};
    tbl[4]  = '{4'd2, 16'hB002, 1'b0, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0, 16'h0};
    tbl[5]  = '{4'd4, 16'hC003, 1'b0, 3'd0, 1'b0, 1'b0, 4'd2, 1'b0, 16'h0};
    tbl[6]  = '{4'd4, 16'hC003, 1'b0, 3'd0, 1'b0, 1'b0, 4'd2, 1'b0, 16'h0};
    tbl[7]  = '{4'd8, 16'hD004, 1'b0, 3'd0, 1'b0, 1'b0, 4'd3, 1'b0, 16'h0};
    tbl[8]  = '{4'd8, 16'hD004, 1'b0, 3'd0, 1'b0, 1'b0, 4'd3, 1'b0, 16'h0};
    tbl[9]  = '{4'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 4'd4, 1'b0, 16'h0};
    tbl[10] = '{4'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 4'd4, 1'b0, 16'h0};
    tbl[11] = '{4'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b0, 4'd4, 1'b1, 16'hA001};
    tbl[12] = '{4'd0, 16'h0000, 1'b1, 3'd1, 1'b1, 1'b0, 4'd4, 1'b1, 16'hB002};
    tbl[13] = '{4'd0, 16'h0000, 1'b1, 3'd2, 1'b1, 1'b0, 4'd4, 1'b1, 16'hC003};
    tbl[14] = '{4'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 1'b0, 4'd4, 1'b1, 16'hD004};
    tbl[15] = '{4'd0, 16'h0000, 1'b1, 3'd7, 1'b1, 1'b0, 4'd4, 1'b1, 16'h0000};
    tbl[16] = '{4'd5, 16'hFFFF, 1'b0, 3'd0, 1'b1, 1'b0, 4'd4, 1'b0, 16'h0};

    do_reset();
    check_status("reset", 1'b0, 1'b0, '0, '0);
    check("reset.rbv", 32'(rb_valid), 32'd0);
    check("reset.rbd", 32'(rb_data), 32'd0);

    for (int i = 0; i < 17; i++) begin
      configs_en = tbl[i].en; configs_in = tbl[i].data;
      rb_en = tbl[i].rbe; rb_addr = tbl[i].rba;
      step();
      check($sformatf("nom[%0d].done", i), 32'(cfg_done), 32'(tbl[i].done));
      check($sformatf("nom[%0d].err", i),  32'(cfg_err),  32'(tbl[i].err));
      check($sformatf("nom[%0d].cnt", i),  32'(cfg_frame_cnt), 32'(tbl[i].cnt));
      check($sformatf("nom[%0d].rbv", i),  32'(rb_valid), 32'(tbl[i].rbv));
      if (tbl[i].rbv) check($sformatf("nom[%0d].rbd", i), 32'(rb_data), 32'(tbl[i].rbd));
    end
    rb_en = 1'b0;
`ifdef CFG_RX_CHECKSUM_EN
    frames = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    check("nom.csum", 32'(cfg_checksum), 32'(model_csum(frames)));
`endif

    // ---- skipped frame ----
    do_reset();
    drive(4'd1, 16'h1234);
    drive(4'd4, 16'h5555);
    check_status("skip", 1'b0, 1'b1, 3'd0, 4'd0);
    drive(4'd2, 16'h1111);
    drive(4'd0, 16'h0000);
    check_status("skip_abs", 1'b0, 1'b1, 3'd0, 4'd0);

    // ---- multi-hot ----
    do_reset();
    drive(4'd1, 16'h0101);
    drive(4'd2, 16'h0202);
    check("mhot.cnt1", 32'(cfg_frame_cnt), 32'd1);
    drive(4'd6, 16'h0303);
    check_status("mhot", 1'b0, 1'b1, 3'd1, 4'd1);
    rb_read(3'd0, 16'h0101, "mhot.rb0");

    // ---- early zero ----
    do_reset();
    drive(4'd1, 16'h0A0A);
    drive(4'd2, 16'h0B0B);
    drive(4'd0, 16'h0000);
    check_status("ezero", 1'b0, 1'b1, 3'd1, 4'd1);

    // ---- reset mid-load, then reload ----
    do_reset();
    drive(4'd1, 16'h1111);
    drive(4'd2, 16'h2222);
    drive(4'd4, 16'h3333);
    rst = 1'b1; rb_en = 1'b1; rb_addr = 3'd0;
    step();
    rst = 1'b0; rb_en = 1'b0; configs_en = '0;
    check_status("midrst", 1'b0, 1'b0, 3'd0, 4'd0);
    check("midrst.rbv", 32'(rb_valid), 32'd0);
    check("midrst.rbd", 32'(rb_data), 32'd0);
    rb_read(3'd0, 16'h1111, "midrst.keep0");
    rb_read(3'd1, 16'h2222, "midrst.keep1");
    full_load(16'h6000);
    check_status("reload", 1'b1, 1'b0, 3'd0, 4'd4);
    for (int i = 0; i < NF; i++) rb_read(IW'(i), 16'h6000 + FW'(i), $sformatf("reload.rb%0d", i));

    // ---- read and commit to the same index in one cycle ----
    do_reset();
    drive(4'd1, 16'h7771);
    drive(4'd2, 16'h7772);
    exp_q.push_back(16'h6001);
    configs_en = 4'd4; configs_in = 16'h7773; rb_en = 1'b1; rb_addr = 3'd1;
    step();
    rb_en = 1'b0;
    check("same.valid", 32'(rb_valid), 32'd1);
    check("same.old", 32'(rb_data), 32'(exp_q.pop_front()));
    check("same.cnt", 32'(cfg_frame_cnt), 32'd2);
    rb_read(3'd1, 16'h7772, "same.new");

    // ---- randomized loads against the generator-derived reference ----
    for (int t = 0; t < 40; t++) begin
      do_reset();
      frames.delete();
      err_at = $urandom_range(0, 5);
      if (err_at == 5) begin
        bad = NF'($urandom_range(2, 15));
        drive(bad, FW'($urandom));
      end else begin
        for (int f = 0; f < NF; f++) begin
          hold = $urandom_range(1, 3);
          for (int h = 0; h < hold; h++) begin
            last_d = FW'($urandom);
            drive(NF'(1 << f), last_d);
          end
          if (f == err_at) begin
            legal_next = (f < NF - 1) ? (1 << (f + 1)) : 0;
            do bad = NF'($urandom_range(0, 15));
            while (int'(bad) == (1 << f) || int'(bad) == legal_next);
            drive(bad, FW'($urandom));
            break;
          end
          frames.push_back(last_d);
        end
        if (err_at == 4) drive('0, FW'($urandom));
      end
      check_status($sformatf("rnd%0d", t), err_at == 4, err_at != 4,
                   (err_at < 4) ? IW'(err_at) : IW'(0), (IW+1)'(frames.size()));
      drive(NF'($urandom), FW'($urandom));
      drive(NF'($urandom), FW'($urandom));
      check_status($sformatf("rnd%0d.abs", t), err_at == 4, err_at != 4,
                   (err_at < 4) ? IW'(err_at) : IW'(0), (IW+1)'(frames.size()));
      foreach (frames[i]) rb_read(IW'(i), frames[i], $sformatf("rnd%0d.rb%0d", t, i));
      rb_read(IW'($urandom_range(NF, 7)), 16'h0000, $sformatf("rnd%0d.oor", t));
`ifdef CFG_RX_CHECKSUM_EN
      check($sformatf("rnd%0d.csum", t), 32'(cfg_checksum), 32'(model_csum(frames)));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
